// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg: shared definitions for the UART echo checker.
// Holds the FSM state encoding, the default far-end increment and the
// LFSR tap mask used when UART_ECHO_CHECKER_LFSR_EN is defined.
package uart_echo_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_RX = 3'd2,
    CHECK   = 3'd3,
    GAP     = 3'd4
  } state_t;

  // The mirror board returns every byte plus one.
  localparam int DEF_EXPECT_INC = 1;

  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/uart_pattern_gen.sv
// uart_pattern_gen: byte pattern source for the echo checker.
// Starts at SEED and moves to the next value on each i_step.
// Build option UART_ECHO_CHECKER_LFSR_EN: Fibonacci LFSR (shift left,
// feedback into bit 0, period 255, never 0); otherwise a wrapping +1 counter.
module uart_pattern_gen
  import uart_echo_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_step,
  output logic [WIDTH-1:0] ov_pattern
);

  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] pattern_next;

`ifdef UART_ECHO_CHECKER_LFSR_EN
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);
  assign pattern_next = {pattern_q[WIDTH-2:0], ^(pattern_q & TAPS)};
`else
  assign pattern_next = pattern_q + 1'b1;
`endif

  // Pattern register: holds SEED after reset, advances once per transaction.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pattern_q <= SEED;
    end else if (i_step) begin
      pattern_q <= pattern_next;
    end
  end

  assign ov_pattern = pattern_q;

endmodule

// File: rtl/uart_echo_checker.sv
// uart_echo_checker: sends one pattern byte per transaction to a UART
// transmitter, waits for the mirror's echo and checks echo == sent + EXPECT_INC
// (modulo 2^WIDTH). Keeps saturating pass / error / timeout counters.
// Build option: UART_ECHO_CHECKER_LFSR_EN selects the LFSR pattern inside
// uart_pattern_gen; ports and timing are identical in both builds.
//
// state   | meaning
// IDLE    | stopped, waiting for i_start
// SEND    | one-cycle send strobe once the transmitter is not busy
// WAIT_RX | waiting for a rising rx-ready edge, else timeout
// CHECK   | compare captured echo with the expected byte
// GAP     | spacing between transactions; also waits for tx idle
module uart_echo_checker
  import uart_echo_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter int               EXPECT_INC     = DEF_EXPECT_INC,
  parameter int               TIMEOUT_CYCLES = 50000,
  parameter int               GAP_CYCLES     = 16,
  parameter logic [WIDTH-1:0] SEED           = WIDTH'(8'h01),
  parameter int               CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  output logic [WIDTH-1:0] ov_tx_data,
  output logic             o_tx_send,
  input  logic             i_tx_busy,
  input  logic [WIDTH-1:0] iv_rx_data,
  input  logic             i_rx_data_ready,
  output logic             o_running,
  output logic             o_last_ok,
  output logic [WIDTH-1:0] ov_last_rx,
  output logic [CNT_W-1:0] ov_pass_count,
  output logic [CNT_W-1:0] ov_err_count,
  output logic [CNT_W-1:0] ov_timeout_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  state_t           state_q, state_d;
  logic             ready_last_q;
  logic             rx_edge;
  logic [TMR_W-1:0] timer_q;
  logic [GAP_W-1:0] gap_q;
  logic             timeout_hit;
  logic             gap_done;
  logic [WIDTH-1:0] pattern;
  logic             pattern_step;
  logic [WIDTH-1:0] expected_q;
  logic [WIDTH-1:0] tx_data_q;
  logic [WIDTH-1:0] last_rx_q;
  logic             last_ok_q;
  logic [CNT_W-1:0] pass_q, err_q, tmo_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  uart_pattern_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_pattern_gen (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_step     (pattern_step),
    .ov_pattern (pattern)
  );

  // Ready history resets high so a level already high after reset is no edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) ready_last_q <= 1'b1;
    else            ready_last_q <= i_rx_data_ready;
  end

  assign rx_edge     = i_rx_data_ready & ~ready_last_q;
  assign timeout_hit = (timer_q == '0);
  assign gap_done    = (gap_q <= GAP_W'(1)) && !i_tx_busy;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; an echo edge wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = SEND;
      SEND:    if (!i_tx_busy) state_d = WAIT_RX;
      WAIT_RX: begin
        if (rx_edge)          state_d = CHECK;
        else if (timeout_hit) state_d = GAP;
      end
      CHECK:   state_d = GAP;
      GAP:     if (gap_done) state_d = i_start ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore/strobe outputs; tx data shows the live pattern during SEND.
  always_comb begin
    o_tx_send    = (state_q == SEND) && !i_tx_busy;
    ov_tx_data   = (state_q == SEND) ? pattern : tx_data_q;
    o_running    = (state_q != IDLE);
    pattern_step = (state_q == GAP) && gap_done;
  end

  // Timers, captured bytes, result flag and saturating statistics.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timer_q    <= '0;
      gap_q      <= '0;
      expected_q <= '0;
      tx_data_q  <= '0;
      last_rx_q  <= '0;
      last_ok_q  <= 1'b0;
      pass_q     <= '0;
      err_q      <= '0;
      tmo_q      <= '0;
    end else begin
      case (state_q)
        SEND: begin
          if (!i_tx_busy) begin
            tx_data_q  <= pattern;
            expected_q <= pattern + WIDTH'(EXPECT_INC);
            timer_q    <= TMR_W'(TIMEOUT_CYCLES - 1);
          end
        end
        WAIT_RX: begin
          if (rx_edge) begin
            last_rx_q <= iv_rx_data;
          end else if (timeout_hit) begin
            tmo_q     <= sat_inc(tmo_q);
            last_ok_q <= 1'b0;
            gap_q     <= GAP_W'(GAP_CYCLES);
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        CHECK: begin
          if (last_rx_q == expected_q) begin
            pass_q    <= sat_inc(pass_q);
            last_ok_q <= 1'b1;
          end else begin
            err_q     <= sat_inc(err_q);
            last_ok_q <= 1'b0;
          end
          gap_q <= GAP_W'(GAP_CYCLES);
        end
        GAP: begin
          if (gap_q != '0) gap_q <= gap_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_last_ok        = last_ok_q;
  assign ov_last_rx       = last_rx_q;
  assign ov_pass_count    = pass_q;
  assign ov_err_count     = err_q;
  assign ov_timeout_count = tmo_q;

endmodule
